// File: rtl/div_result_display.sv
// Converts divider results to 2-digit BCD by sequential double-dabble and drives
// a 4-digit multiplexed 7-segment display laid out as QQ RR (dashes on divide-by-zero).
module div_result_display #(
    parameter int SCAN_DIV       = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] quotient,
    input  logic [3:0] remainder,
    input  logic       div_zero,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] dig_en
);
    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] SEG_MASK  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0] CODE_DASH = 7'h40;
    localparam logic [6:0] CODE_BLNK = 7'h00;

    typedef enum logic {IDLE, CONV} state_t;

    state_t     state_q;
    logic       in_ready_q, busy_q;
    logic [2:0] step_q;
    logic [7:0] bcd_q;
    logic [3:0] shift_q;
    logic [3:0] rem_q;
    logic [7:0] qbcd_q;
    logic       dz_q;

    logic [6:0]       disp_q [4];
    logic [6:0]       disp_d [4];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [6:0]       seg_q;
    logic [3:0]       dig_en_q;

    logic [11:0] dab;
    logic        load_disp;

    // One double-dabble iteration: correct each BCD nibble, then shift in the next bit.
    function automatic logic [11:0] dabble(input logic [7:0] b_in, input logic [3:0] s_in);
        logic [7:0] b;
        b = b_in;
        if (b[3:0] >= 4'd5) b[3:0] = b[3:0] + 4'd3;
        if (b[7:4] >= 4'd5) b[7:4] = b[7:4] + 4'd3;
        return {b, s_in} << 1;
    endfunction

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h3F;
            4'd1:    c = 7'h06;
            4'd2:    c = 7'h5B;
            4'd3:    c = 7'h4F;
            4'd4:    c = 7'h66;
            4'd5:    c = 7'h6D;
            4'd6:    c = 7'h7D;
            4'd7:    c = 7'h07;
            4'd8:    c = 7'h7F;
            4'd9:    c = 7'h6F;
            default: c = CODE_BLNK;
        endcase
        return c;
    endfunction

    function automatic logic [6:0] tens_code(input logic [3:0] d);
        return (BLANK_LEADING && d == 4'd0) ? CODE_BLNK : digit_code(d);
    endfunction

    assign dab       = dabble(bcd_q, shift_q);
    assign load_disp = (state_q == CONV) && (step_q == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            step_q     <= 3'd0;
            bcd_q      <= 8'd0;
            shift_q    <= 4'd0;
            rem_q      <= 4'd0;
            qbcd_q     <= 8'd0;
            dz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= CONV;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        step_q     <= 3'd0;
                        bcd_q      <= 8'd0;
                        shift_q    <= quotient;
                        rem_q      <= remainder;
                        dz_q       <= div_zero;
                    end
                end
                CONV: begin
                    step_q <= step_q + 3'd1;
                    // After the fourth quotient iteration, park Q and restart on R.
                    if (step_q == 3'd3) begin
                        qbcd_q  <= dab[11:4];
                        bcd_q   <= 8'd0;
                        shift_q <= rem_q;
                    end else begin
                        bcd_q   <= dab[11:4];
                        shift_q <= dab[3:0];
                    end
                    if (step_q == 3'd7) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        disp_d = disp_q;
        if (load_disp) begin
            if (dz_q) begin
                disp_d[3] = CODE_DASH;
                disp_d[2] = CODE_DASH;
                disp_d[1] = CODE_DASH;
                disp_d[0] = CODE_DASH;
            end else begin
                disp_d[3] = tens_code(qbcd_q[7:4]);
                disp_d[2] = digit_code(qbcd_q[3:0]);
                disp_d[1] = tens_code(dab[11:8]);
                disp_d[0] = digit_code(dab[7:4]);
            end
        end
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // seg is taken from the next-state display and index so it always matches dig_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) disp_q[i] <= CODE_BLNK;
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            seg_q    <= CODE_BLNK ^ SEG_MASK;
            dig_en_q <= 4'b0001;
        end else begin
            disp_q   <= disp_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            seg_q    <= disp_d[idx_d] ^ SEG_MASK;
            dig_en_q <= 4'b0001 << idx_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign seg      = seg_q;
    assign dig_en   = dig_en_q;
endmodule

// File: tb/tb_div_result_display.sv
// Directed bench for div_result_display: three instances share stimulus to cover
// leading-zero blanking on/off and active-low segments with a fast scan.
module tb_div_result_display;
    logic       clk = 1'b0;
    logic       rst, in_valid, div_zero;
    logic [3:0] quotient, remainder;
    logic       rdy_a, rdy_b, rdy_c, busy_a, busy_b, busy_c;
    logic [6:0] seg_a, seg_b, seg_c;
    logic [3:0] den_a, den_b, den_c;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_a [4];
    logic [7:0] cap_b [4];
    logic [7:0] cap_c [4];

    always #5 clk = ~clk;

    div_result_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .quotient(quotient),
        .remainder(remainder), .div_zero(div_zero), .busy(busy_a), .seg(seg_a), .dig_en(den_a));
    div_result_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .quotient(quotient),
        .remainder(remainder), .div_zero(div_zero), .busy(busy_b), .seg(seg_b), .dig_en(den_b));
    div_result_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .quotient(quotient),
        .remainder(remainder), .div_zero(div_zero), .busy(busy_c), .seg(seg_c), .dig_en(den_c));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h", tag, obs, exp);
        end else begin
            $display("ok   %s: %02h", tag, obs);
        end
    endtask

    // Record what each instance shows on each digit over one full scan (16 clocks).
    task automatic capture();
        for (int d = 0; d < 4; d++) begin
            cap_a[d] = 8'hEE; cap_b[d] = 8'hEE; cap_c[d] = 8'hEE;
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (den_a == (4'b0001 << d)) cap_a[d] = {1'b0, seg_a};
                if (den_b == (4'b0001 << d)) cap_b[d] = {1'b0, seg_b};
                if (den_c == (4'b0001 << d)) cap_c[d] = {1'b0, seg_c};
            end
        end
    endtask

    task automatic expect_digits(input string tag, input logic [7:0] ea [4], input logic [7:0] eb [4]);
        capture();
        for (int d = 3; d >= 0; d--) begin
            check($sformatf("%s a.dig%0d", tag, d), cap_a[d], ea[d]);
            check($sformatf("%s b.dig%0d", tag, d), cap_b[d], eb[d]);
            check($sformatf("%s c.dig%0d", tag, d), cap_c[d], ea[d] ^ 8'h7F);
        end
    endtask

    // Handshake one result and measure how long busy stays high.
    task automatic send(input string tag, input logic [3:0] q, input logic [3:0] r, input logic dz);
        int n;
        @(negedge clk);
        in_valid = 1'b1; quotient = q; remainder = r; div_zero = dz;
        @(negedge clk);
        in_valid = 1'b0; quotient = 4'hX; remainder = 4'hX; div_zero = 1'bX;
        check({tag, " in_ready low"}, {7'd0, rdy_a}, 8'd0);
        n = 0;
        while (busy_a && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy cycles"}, 8'(n), 8'd8);
        check({tag, " in_ready back"}, {7'd0, rdy_a}, 8'd1);
    endtask

    initial begin
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        int n;
        rst = 1'b1; in_valid = 1'b0; quotient = 4'd0; remainder = 4'd0; div_zero = 1'b0;

        // Reset for two clocks, then watch the fast scan rotate.
        @(negedge clk); @(negedge clk);
        check("rst in_ready", {7'd0, rdy_a}, 8'd1);
        check("rst busy", {7'd0, busy_a}, 8'd0);
        check("rst dig_en", {4'd0, den_a}, 8'h01);
        check("rst seg", {1'b0, seg_a}, 8'h00);
        check("rst seg active-low", {1'b0, seg_c}, 8'h7F);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k % 4 == 2 || k == 16)
                check($sformatf("scan edge%0d dig_en", k), {4'd0, den_c},
                      8'(4'b0001 << ((k / 4) % 4)));
        end
        ea = '{8'h00, 8'h00, 8'h00, 8'h00};
        expect_digits("blank after rst", ea, ea);

        send("Q3R2", 4'd3, 4'd2, 1'b0);
        ea = '{8'h5B, 8'h00, 8'h4F, 8'h00};
        eb = '{8'h5B, 8'h3F, 8'h4F, 8'h3F};
        expect_digits("Q3R2", ea, eb);

        send("Q10R9", 4'd10, 4'd9, 1'b0);
        ea = '{8'h6F, 8'h00, 8'h3F, 8'h06};
        eb = '{8'h6F, 8'h3F, 8'h3F, 8'h06};
        expect_digits("Q10R9", ea, eb);

        send("Q15R0", 4'd15, 4'd0, 1'b0);
        ea = '{8'h3F, 8'h00, 8'h6D, 8'h06};
        eb = '{8'h3F, 8'h3F, 8'h6D, 8'h06};
        expect_digits("Q15R0", ea, eb);

        send("div0", 4'd9, 4'd9, 1'b1);
        ea = '{8'h40, 8'h40, 8'h40, 8'h40};
        expect_digits("div0", ea, ea);

        // in_valid held through busy: the second result waits for the first idle cycle.
        @(negedge clk);
        in_valid = 1'b1; quotient = 4'd1; remainder = 4'd1; div_zero = 1'b0;
        @(negedge clk);
        quotient = 4'd7; remainder = 4'd1;
        n = 0;
        while (busy_a && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("held busy cycles", 8'(n), 8'd8);
        check("held in_ready idle", {7'd0, rdy_a}, 8'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("held accepted busy", {7'd0, busy_a}, 8'd1);
        check("held accepted in_ready", {7'd0, rdy_a}, 8'd0);
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("pre-abort busy", {7'd0, busy_a}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", {7'd0, busy_a}, 8'd0);
        check("abort in_ready", {7'd0, rdy_a}, 8'd1);
        check("abort dig_en", {4'd0, den_a}, 8'h01);
        check("abort seg", {1'b0, seg_a}, 8'h00);
        ea = '{8'h00, 8'h00, 8'h00, 8'h00};
        expect_digits("after abort", ea, ea);
        check("idle after abort", {7'd0, busy_a}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
